// File: rtl/song_sequencer.sv
// song_sequencer: walks an external synchronous note ROM through a table of songs,
// one address step per tempo tick, with play/pause, loop or one-shot, and song restart.

module song_sequencer_chk #(
  parameter int N_SONGS = 4
) (
  input logic               clk,
  input logic               rst,
  input logic [N_SONGS-1:0] cfg_bad
);

  cfg_ok: assert property (@(posedge clk) disable iff (rst) cfg_bad == {N_SONGS{1'b0}})
    else $error("song_sequencer: song table entry with START > END, mask %b", cfg_bad);

endmodule

module song_sequencer #(
  parameter int ADDR_W  = 10,
  parameter int NOTE_W  = 5,
  parameter int N_SONGS = 4,
  parameter int SEL_W   = 2,
  parameter logic [N_SONGS*ADDR_W-1:0] START_TAB = {10'd688, 10'd464, 10'd328, 10'd0},
  parameter logic [N_SONGS*ADDR_W-1:0] END_TAB   = {10'd808, 10'd680, 10'd456, 10'd320}
) (
  input  logic              inclock,
  input  logic              rst,
  input  logic              tick,
  input  logic [SEL_W-1:0]  sel,
  input  logic              play,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [NOTE_W-1:0] rom_q,
  output logic [NOTE_W-1:0] note,
  output logic              note_valid,
  output logic              busy,
  output logic              song_done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int N_SLOTS = 2 ** SEL_W;
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] start_tab_s [N_SLOTS];
  logic [ADDR_W-1:0] end_tab_s   [N_SLOTS];
  logic [N_SONGS-1:0] cfg_bad_s;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SEL_W-1:0]  sel_q;
  logic              load_q, load_d;
  logic              rd_q, rd_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic              note_valid_q, note_valid_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              sel_change_s;

  // Unused select codes alias song 0, so the tables can be indexed by sel directly.
  for (genvar k = 0; k < N_SLOTS; k++) begin : g_tab
    if (k < N_SONGS) begin : g_song
      assign start_tab_s[k] = START_TAB[k*ADDR_W +: ADDR_W];
      assign end_tab_s[k]   = END_TAB[k*ADDR_W +: ADDR_W];
      assign cfg_bad_s[k]   = (START_TAB[k*ADDR_W +: ADDR_W] > END_TAB[k*ADDR_W +: ADDR_W]);
    end else begin : g_alias
      assign start_tab_s[k] = START_TAB[ADDR_W-1:0];
      assign end_tab_s[k]   = END_TAB[ADDR_W-1:0];
    end
  end

  song_sequencer_chk #(.N_SONGS(N_SONGS)) u_chk (
    .clk     (inclock),
    .rst     (rst),
    .cfg_bad (cfg_bad_s)
  );

  assign sel_change_s = (sel != sel_q);

  // Next state and next address; a song change outranks pause, tick and end-of-song.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    load_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (play) begin
          state_d = S_PLAY;
          addr_d  = start_tab_s[sel];
          load_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PLAY: begin
        if (sel_change_s) begin
          addr_d = start_tab_s[sel];
          if (play) begin
            load_d = 1'b1;
          end else begin
            state_d = S_PAUSE;
          end
        end else if (!play) begin
          state_d = S_PAUSE;
        end else if (tick) begin
          if (addr_q < end_tab_s[sel]) begin
            addr_d = addr_q + ADDR_ONE;
            load_d = 1'b1;
          end else if (loop_en) begin
            addr_d = start_tab_s[sel];
            load_d = 1'b1;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          state_d = S_PLAY;
        end
      end
      S_PAUSE: begin
        if (sel_change_s) begin
          addr_d = start_tab_s[sel];
        end else begin
          addr_d = addr_q;
        end
        if (play) begin
          state_d = S_PLAY;
          load_d  = 1'b1;
        end else begin
          state_d = S_PAUSE;
        end
      end
      S_DONE: begin
        if (sel_change_s && play) begin
          state_d = S_PLAY;
          addr_d  = start_tab_s[sel];
          load_d  = 1'b1;
        end else if (sel_change_s || !play) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        addr_d  = start_tab_s[sel];
      end
    endcase
  end

  // Note capture: rom_q is live one cycle after the address register loads.
  always_comb begin
    rd_d         = 1'b0;
    note_d       = note_q;
    note_valid_d = note_valid_q;
    busy_d       = (state_d == S_PLAY) || (state_d == S_PAUSE);
    if (state_d == S_PLAY) begin
      rd_d = load_q;
      if (rd_q) begin
        note_d       = rom_q;
        note_valid_d = 1'b1;
      end else begin
        note_d       = note_q;
        note_valid_d = note_valid_q;
      end
    end else begin
      note_d       = {NOTE_W{1'b0}};
      note_valid_d = 1'b0;
    end
  end

  // State, address and output registers with synchronous reset.
  always_ff @(posedge inclock) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= start_tab_s[sel];
      sel_q        <= sel;
      load_q       <= 1'b0;
      rd_q         <= 1'b0;
      note_q       <= {NOTE_W{1'b0}};
      note_valid_q <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      sel_q        <= sel;
      load_q       <= load_d;
      rd_q         <= rd_d;
      note_q       <= note_d;
      note_valid_q <= note_valid_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign rom_addr   = addr_q;
  assign note       = note_q;
  assign note_valid = note_valid_q;
  assign busy       = busy_q;
  assign song_done  = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench for song_sequencer: expected addresses and notes are queued as
// ticks are driven and compared when the sequencer presents them.
module tb_song_sequencer;

  logic       clk = 1'b0;
  logic       rst, tick, play, loop_en;
  logic [1:0] sel;
  logic [9:0] rom_addr;
  logic [4:0] rom_q, note;
  logic       note_valid, busy, song_done;

  logic       rst2, tick2, play2;
  logic [1:0] sel2;
  logic [9:0] rom_addr2;
  logic [4:0] rom_q2, note2;
  logic       note_valid2, busy2, song_done2;

  int checks = 0;
  int passed = 0;
  int done_pulses = 0;
  logic [9:0] q_addr[$];
  logic [4:0] q_note[$];

  always #5 clk = ~clk;

  song_sequencer dut (
    .inclock(clk), .rst(rst), .tick(tick), .sel(sel), .play(play), .loop_en(loop_en),
    .rom_addr(rom_addr), .rom_q(rom_q), .note(note), .note_valid(note_valid),
    .busy(busy), .song_done(song_done)
  );

  song_sequencer #(
    .N_SONGS(3),
    .START_TAB({10'd464, 10'd328, 10'd0}),
    .END_TAB({10'd680, 10'd456, 10'd320})
  ) dut3 (
    .inclock(clk), .rst(rst2), .tick(tick2), .sel(sel2), .play(play2), .loop_en(loop_en),
    .rom_addr(rom_addr2), .rom_q(rom_q2), .note(note2), .note_valid(note_valid2),
    .busy(busy2), .song_done(song_done2)
  );

  function automatic logic [4:0] rom_val(input logic [9:0] a);
    logic [9:0] t;
    t = (a * 10'd7) + 10'd1;
    return t[4:0];
  endfunction

  always @(posedge clk) begin
    rom_q  <= rom_val(rom_addr);
    rom_q2 <= rom_val(rom_addr2);
  end

  always @(negedge clk) begin
    if (song_done === 1'b1) done_pulses <= done_pulses + 1;
  end

  task automatic pulse_tick(input logic [9:0] exp_addr);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    q_addr.push_back(exp_addr);
    q_note.push_back(rom_val(exp_addr));
  endtask

  task automatic start_song(input logic [1:0] s, input logic lp);
    rst = 1'b1; sel = s; play = 1'b0; tick = 1'b0; loop_en = lp;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    play = 1'b1;
    @(negedge clk);
    q_addr.push_back(dut_start(s));
    q_note.push_back(rom_val(dut_start(s)));
  endtask

  function automatic logic [9:0] dut_start(input logic [1:0] s);
    case (s)
      2'd0: return 10'd0;
      2'd1: return 10'd328;
      2'd2: return 10'd464;
      default: return 10'd688;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1; sel = 2'd1; play = 1'b0; tick = 1'b0; loop_en = 1'b1;
    @(negedge clk);
    checks++; if (rom_addr !== 10'd328) $display("FAIL reset_addr_sel1: got %0d expected 328", rom_addr); else passed++;
    sel = 2'd0;
    @(negedge clk);
    checks++; if (rom_addr !== 10'd0) $display("FAIL reset_addr_sel0: got %0d expected 0", rom_addr); else passed++;
    checks++;
    if (note !== 5'd0 || note_valid !== 1'b0 || busy !== 1'b0 || song_done !== 1'b0)
      $display("FAIL reset_outputs: note %0d valid %b busy %b done %b expected all 0", note, note_valid, busy, song_done);
    else passed++;
  endtask

  task automatic test_play_song0();
    logic [9:0] ea;
    logic [4:0] en;
    start_song(2'd0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) pulse_tick(10'(i));
      ea = q_addr.pop_front();
      checks++; if (rom_addr !== ea || busy !== 1'b1) $display("FAIL play0_addr: got %0d busy %b expected %0d busy 1", rom_addr, busy, ea); else passed++;
      repeat (2) @(negedge clk);
      en = q_note.pop_front();
      checks++; if (note !== en || note_valid !== 1'b1) $display("FAIL play0_note: got %0d valid %b expected %0d valid 1", note, note_valid, en); else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_loop_song1();
    logic [9:0] ea, cur;
    logic [4:0] en;
    start_song(2'd1, 1'b1);
    done_pulses = 0;
    cur = 10'd328;
    for (int i = 0; i <= 130; i++) begin
      if (i > 0) begin
        cur = (cur == 10'd456) ? 10'd328 : cur + 10'd1;
        pulse_tick(cur);
      end
      ea = q_addr.pop_front();
      checks++; if (rom_addr !== ea || busy !== 1'b1) $display("FAIL loop_addr: got %0d busy %b expected %0d busy 1", rom_addr, busy, ea); else passed++;
      repeat (2) @(negedge clk);
      en = q_note.pop_front();
      checks++; if (note !== en || note_valid !== 1'b1) $display("FAIL loop_note: got %0d valid %b expected %0d valid 1", note, note_valid, en); else passed++;
      @(negedge clk);
    end
    checks++; if (done_pulses != 0) $display("FAIL loop_no_done: got %0d pulses expected 0", done_pulses); else passed++;
  endtask

  task automatic test_oneshot_song3();
    logic [9:0] ea, cur;
    logic [4:0] en;
    start_song(2'd3, 1'b0);
    cur = 10'd688;
    for (int i = 0; i <= 120; i++) begin
      if (i > 0) begin
        cur = cur + 10'd1;
        pulse_tick(cur);
      end
      ea = q_addr.pop_front();
      checks++; if (rom_addr !== ea) $display("FAIL oneshot_addr: got %0d expected %0d", rom_addr, ea); else passed++;
      repeat (2) @(negedge clk);
      en = q_note.pop_front();
      checks++; if (note !== en || note_valid !== 1'b1) $display("FAIL oneshot_note: got %0d valid %b expected %0d valid 1", note, note_valid, en); else passed++;
      @(negedge clk);
    end
    done_pulses = 0;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    checks++;
    if (song_done !== 1'b1 || rom_addr !== 10'd808 || note !== 5'd0 || note_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL oneshot_end: done %b addr %0d note %0d valid %b busy %b expected 1 808 0 0 0", song_done, rom_addr, note, note_valid, busy);
    else passed++;
    @(negedge clk);
    checks++; if (song_done !== 1'b0) $display("FAIL oneshot_pulse_width: got %b expected 0", song_done); else passed++;
    repeat (3) begin
      tick = 1'b1; @(negedge clk); tick = 1'b0; @(negedge clk);
    end
    checks++;
    if (rom_addr !== 10'd808 || done_pulses != 1)
      $display("FAIL oneshot_hold: addr %0d pulses %0d expected 808 and 1", rom_addr, done_pulses);
    else passed++;
  endtask

  task automatic test_song_change();
    logic [9:0] ea;
    logic [4:0] en;
    start_song(2'd2, 1'b1);
    void'(q_addr.pop_front());
    void'(q_note.pop_front());
    for (int i = 1; i <= 36; i++) begin
      pulse_tick(10'(464 + i));
      ea = q_addr.pop_front();
      void'(q_note.pop_front());
      checks++; if (rom_addr !== ea) $display("FAIL change_walk_addr: got %0d expected %0d", rom_addr, ea); else passed++;
    end
    repeat (2) @(negedge clk);
    sel = 2'd0;
    pulse_tick(10'd0);
    ea = q_addr.pop_front();
    checks++; if (rom_addr !== ea) $display("FAIL change_addr: got %0d expected %0d", rom_addr, ea); else passed++;
    repeat (2) @(negedge clk);
    en = q_note.pop_front();
    checks++; if (note !== en || note_valid !== 1'b1) $display("FAIL change_note: got %0d valid %b expected %0d valid 1", note, note_valid, en); else passed++;
    @(negedge clk);
    pulse_tick(10'd1);
    ea = q_addr.pop_front();
    void'(q_note.pop_front());
    checks++; if (rom_addr !== ea) $display("FAIL change_next_addr: got %0d expected %0d", rom_addr, ea); else passed++;
  endtask

  task automatic test_pause();
    logic [9:0] ea;
    logic [4:0] en;
    start_song(2'd2, 1'b1);
    void'(q_addr.pop_front());
    void'(q_note.pop_front());
    for (int i = 1; i <= 6; i++) begin
      pulse_tick(10'(464 + i));
      void'(q_addr.pop_front());
      void'(q_note.pop_front());
    end
    repeat (3) @(negedge clk);
    play = 1'b0;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    checks++;
    if (rom_addr !== 10'd470 || busy !== 1'b1 || note !== 5'd0 || note_valid !== 1'b0)
      $display("FAIL pause_enter: addr %0d busy %b note %0d valid %b expected 470 1 0 0", rom_addr, busy, note, note_valid);
    else passed++;
    for (int i = 0; i < 20; i++) begin
      tick = 1'b1; @(negedge clk); tick = 1'b0; @(negedge clk);
      checks++;
      if (rom_addr !== 10'd470 || note !== 5'd0 || note_valid !== 1'b0)
        $display("FAIL pause_hold: addr %0d note %0d valid %b expected 470 0 0", rom_addr, note, note_valid);
      else passed++;
    end
    play = 1'b1;
    @(negedge clk);
    q_addr.push_back(10'd470);
    q_note.push_back(rom_val(10'd470));
    ea = q_addr.pop_front();
    checks++; if (rom_addr !== ea) $display("FAIL resume_addr: got %0d expected %0d", rom_addr, ea); else passed++;
    repeat (2) @(negedge clk);
    en = q_note.pop_front();
    checks++; if (note !== en || note_valid !== 1'b1) $display("FAIL resume_note: got %0d valid %b expected %0d valid 1", note, note_valid, en); else passed++;
    @(negedge clk);
    pulse_tick(10'd471);
    ea = q_addr.pop_front();
    checks++; if (rom_addr !== ea) $display("FAIL resume_step_addr: got %0d expected %0d", rom_addr, ea); else passed++;
    repeat (2) @(negedge clk);
    en = q_note.pop_front();
    checks++; if (note !== en) $display("FAIL resume_step_note: got %0d expected %0d", note, en); else passed++;
  endtask

  task automatic test_reset_midsong();
    start_song(2'd3, 1'b1);
    void'(q_addr.pop_front());
    void'(q_note.pop_front());
    for (int i = 1; i <= 12; i++) begin
      pulse_tick(10'(688 + i));
      void'(q_addr.pop_front());
      void'(q_note.pop_front());
    end
    repeat (2) @(negedge clk);
    checks++; if (rom_addr !== 10'd700 || note_valid !== 1'b1) $display("FAIL midsong_pre: addr %0d valid %b expected 700 1", rom_addr, note_valid); else passed++;
    rst = 1'b1;
    sel = 2'd2;
    @(negedge clk);
    checks++;
    if (rom_addr !== 10'd464 || busy !== 1'b0 || note !== 5'd0 || note_valid !== 1'b0 || song_done !== 1'b0)
      $display("FAIL midsong_reset: addr %0d busy %b note %0d valid %b done %b expected 464 0 0 0 0", rom_addr, busy, note, note_valid, song_done);
    else passed++;
    play = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || rom_addr !== 10'd464) $display("FAIL midsong_idle: busy %b addr %0d expected 0 464", busy, rom_addr); else passed++;
  endtask

  task automatic test_sel_map();
    logic [9:0] ea;
    logic [4:0] en;
    rst2 = 1'b1; sel2 = 2'b11; play2 = 1'b0; tick2 = 1'b0;
    @(negedge clk);
    checks++; if (rom_addr2 !== 10'd0) $display("FAIL map_reset_addr: got %0d expected 0", rom_addr2); else passed++;
    rst2 = 1'b0;
    @(negedge clk);
    play2 = 1'b1;
    @(negedge clk);
    q_addr.push_back(10'd0);
    q_note.push_back(rom_val(10'd0));
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        tick2 = 1'b1; @(negedge clk); tick2 = 1'b0;
        q_addr.push_back(10'(i));
        q_note.push_back(rom_val(10'(i)));
      end
      ea = q_addr.pop_front();
      checks++; if (rom_addr2 !== ea || busy2 !== 1'b1) $display("FAIL map_addr: got %0d busy %b expected %0d busy 1", rom_addr2, busy2, ea); else passed++;
      repeat (2) @(negedge clk);
      en = q_note.pop_front();
      checks++; if (note2 !== en || note_valid2 !== 1'b1) $display("FAIL map_note: got %0d valid %b expected %0d valid 1", note2, note_valid2, en); else passed++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; sel = 2'd0; play = 1'b0; loop_en = 1'b1;
    rst2 = 1'b1; tick2 = 1'b0; sel2 = 2'd0; play2 = 1'b0;
    test_reset();
    test_play_song0();
    test_loop_song1();
    test_oneshot_song3();
    test_song_change();
    test_pause();
    test_reset_midsong();
    test_sel_map();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
